// File: rtl/if_id_queue_pkg.sv
//------------------------------------------------------------------------------
// if_id_queue_pkg : shared constants and types for the IF/ID fetch queue
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_id_queue_pkg;

   localparam logic [15:0] NOP_INST_DEFAULT = 16'h0000;
   localparam int          STALL_IF         = 1;
   localparam int          STALL_ID         = 2;
   localparam logic        RST_ACTIVE       = 1'b0;

   // Owner of the shared RAM port for the current cycle
   typedef enum logic [1:0] {
      PORT_IDLE  = 2'd0,
      PORT_DATA  = 2'd1,
      PORT_FETCH = 2'd2
   } port_owner_e;

endpackage

`default_nettype wire

// File: rtl/if_id_queue_fetch_fifo.sv
//------------------------------------------------------------------------------
// fetch_fifo : power-of-two FIFO of {pc, inst} pairs with occupancy count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
   import if_id_queue_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int                 PTR_W      = $clog2(DEPTH);
   localparam int                 CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = storage[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
//------------------------------------------------------------------------------
// if_id_queue : shared RAM port arbiter, fetch queue and ID stage registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int                INST_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             stall,
   input  logic                   flush,
   input  logic [ADDR_W-1:0]      if_pc,
   output logic                   if_advance,
   input  logic                   mem_req,
   input  logic                   mem_we,
   input  logic [ADDR_W-1:0]      mem_addr,
   input  logic [INST_W-1:0]      mem_wdata,
   output logic [INST_W-1:0]      mem_rdata,
   output logic [ADDR_W-1:0]      ram_addr_o,
   output logic                   ram_we_o,
   output logic [INST_W-1:0]      ram_wdata_o,
   input  logic [INST_W-1:0]      ram_rdata_i,
   output logic [ADDR_W-1:0]      id_pc,
   output logic [INST_W-1:0]      id_inst,
   output logic                   id_valid,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int ENTRY_W = ADDR_W + INST_W;

   port_owner_e        owner;
   logic               in_reset;
   logic               data_grant;
   logic               fetch_grant;
   logic               id_advance;
   logic               q_empty;
   logic               q_full;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] fetched;
   logic [ENTRY_W-1:0] head;
   logic               unused_stall;

   assign in_reset     = (rst == RST_ACTIVE);
   assign id_advance   = !stall[STALL_ID];
   assign unused_stall = ^{stall[5:3], stall[0]};

   always_comb begin
      owner = PORT_IDLE;
      if (!in_reset && !flush) begin
         if (mem_req) begin
            owner = PORT_DATA;
         end else if (!stall[STALL_IF] && !q_full) begin
            owner = PORT_FETCH;
         end
      end
   end

   assign data_grant  = (owner == PORT_DATA);
   assign fetch_grant = (owner == PORT_FETCH);
   assign if_advance  = fetch_grant;

   always_comb begin
      ram_addr_o  = if_pc;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      mem_rdata   = '0;
      if (data_grant) begin
         ram_addr_o  = mem_addr;
         ram_we_o    = mem_we;
         ram_wdata_o = mem_wdata;
         if (!mem_we) begin
            mem_rdata = ram_rdata_i;
         end
      end
   end

   // A fetch into an empty queue while ID advances skips the queue entirely
   assign fetched = {if_pc, ram_rdata_i};
   assign push    = fetch_grant && !(id_advance && q_empty);
   assign pop     = id_advance && !q_empty && !flush && !in_reset;

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (fetched),
      .pop       (pop),
      .head_data (head),
      .count     (q_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   always_ff @(posedge clk) begin
      if (in_reset || flush) begin
         id_pc    <= '0;
         id_inst  <= NOP_INST;
         id_valid <= 1'b0;
      end else if (id_advance) begin
         if (!q_empty) begin
            {id_pc, id_inst} <= head;
            id_valid         <= 1'b1;
         end else if (fetch_grant) begin
            {id_pc, id_inst} <= fetched;
            id_valid         <= 1'b1;
         end else begin
            id_pc    <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-level reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
`default_nettype none

module tb_if_id_queue;

   localparam int          DEPTH = 4;
   localparam logic [15:0] NOP   = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [15:0] if_pc;
   logic        if_advance;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] ram_addr_o;
   logic        ram_we_o;
   logic [15:0] ram_wdata_o;
   logic [15:0] ram_rdata_i;
   logic [15:0] id_pc;
   logic [15:0] id_inst;
   logic        id_valid;
   logic [2:0]  q_count;

   always #5 clk = ~clk;

   if_id_queue #(
      .INST_W (16),
      .ADDR_W (16),
      .DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .if_pc       (if_pc),
      .if_advance  (if_advance),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_valid    (id_valid),
      .q_count     (q_count)
   );

   // Shared RAM driven by the DUT's port
   logic [15:0] ram [256];
   logic        ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 16'(i) + 16'h1000;
      end else if (ram_we_o) begin
         ram[ram_addr_o[7:0]] <= ram_wdata_o;
      end
   end
   assign ram_rdata_i = ram[ram_addr_o[7:0]];

   // Reference model state
   logic [15:0] m_mem [256];
   logic [31:0] mq [$];
   logic [15:0] m_id_pc, m_id_inst;
   logic        m_id_valid;
   logic        e_adv, e_we;
   logic [15:0] e_addr, e_wdata, e_rdata;
   bit          chk_en;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [5:0] s, input logic f,
                        input logic mr, input logic mw,
                        input logic [15:0] ma, input logic [15:0] md);
      logic dg;
      rst = r; stall = s; flush = f;
      mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
      dg      = r && !f && mr;
      e_adv   = r && !f && !mr && !s[1] && (mq.size() < DEPTH);
      e_we    = dg && mw;
      e_addr  = dg ? ma : if_pc;
      e_wdata = dg ? md : 16'h0000;
      e_rdata = (dg && !mw) ? m_mem[ma[7:0]] : 16'h0000;
      #1;
   endtask

   task automatic tick();
      logic [31:0] ent, hd;
      logic        fetch;
      @(posedge clk);
      fetch = e_adv;
      if (!rst || flush) begin
         mq.delete();
         m_id_pc = 16'h0; m_id_inst = NOP; m_id_valid = 1'b0;
      end else begin
         ent = {if_pc, m_mem[if_pc[7:0]]};
         if (mem_req && mem_we) m_mem[mem_addr[7:0]] = mem_wdata;
         if (!stall[2]) begin
            if (mq.size() != 0) begin
               hd = mq.pop_front();
               {m_id_pc, m_id_inst} = hd;
               m_id_valid = 1'b1;
               if (fetch) mq.push_back(ent);
            end else if (fetch) begin
               {m_id_pc, m_id_inst} = ent;
               m_id_valid = 1'b1;
            end else begin
               m_id_pc = 16'h0; m_id_inst = NOP; m_id_valid = 1'b0;
            end
         end else if (fetch) begin
            mq.push_back(ent);
         end
      end
      chk_en = 1'b1;
      #1;
      if (fetch) if_pc = if_pc + 16'd1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("if_advance",  32'(if_advance),  32'(e_adv));
         check("ram_we_o",    32'(ram_we_o),    32'(e_we));
         check("ram_addr_o",  32'(ram_addr_o),  32'(e_addr));
         check("ram_wdata_o", 32'(ram_wdata_o), 32'(e_wdata));
         check("mem_rdata",   32'(mem_rdata),   32'(e_rdata));
         check("id_pc",       32'(id_pc),       32'(m_id_pc));
         check("id_inst",     32'(id_inst),     32'(m_id_inst));
         check("id_valid",    32'(id_valid),    32'(m_id_valid));
         check("q_count",     32'(q_count),     32'(mq.size()));
      end
   end

   logic [7:0] pat [16];

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = 16'(i) + 16'h1000;
      pat = '{8'b00000000, 8'b00010000, 8'b00001000, 8'b00011000,
              8'b00000010, 8'b00000011, 8'b00010000, 8'b00010000,
              8'b10100100, 8'b00000000, 8'b00010011, 8'b00001000,
              8'b00000000, 8'b00010000, 8'b00000010, 8'b00000000};
      if_pc    = 16'h0000;
      ram_init = 1'b1;

      // Reset with a store pending: nothing may reach the RAM
      drive(1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
      check("rst_ram_we", 32'(ram_we_o), 32'h0);
      check("rst_if_adv", 32'(if_advance), 32'h0);
      tick();
      drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      ram_init = 1'b0;
      check("rst_id_pc",    32'(id_pc),    32'h0);
      check("rst_id_inst",  32'(id_inst),  32'(NOP));
      check("rst_id_valid", 32'(id_valid), 32'h0);
      check("rst_q_count",  32'(q_count),  32'h0);

      // Streaming with bypass: one-cycle fetch-to-ID latency
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
      check("byp_id_pc",    32'(id_pc),    32'h0004);
      check("byp_id_inst",  32'(id_inst),  32'h1004);
      check("byp_id_valid", 32'(id_valid), 32'h1);
      check("byp_q_count",  32'(q_count),  32'h0);

      // ID stalled: queue fills to DEPTH, then fetch stops
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 6'b000100, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         if (k == 5) check("full_if_adv", 32'(if_advance), 32'h0);
         tick();
      end
      check("full_q_count", 32'(q_count), 32'h4);
      check("full_id_hold", 32'(id_pc),   32'h0004);

      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
         if (k == 0) begin
            check("drain_id_pc",   32'(id_pc),   32'h0005);
            check("drain_id_inst", 32'(id_inst), 32'h1005);
            check("drain_q_count", 32'(q_count), 32'h3);
         end
      end

      // Store beats fetch, then load it back
      drive(1'b1, 6'd0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
      check("st_ram_we",   32'(ram_we_o),   32'h1);
      check("st_ram_addr", 32'(ram_addr_o), 32'h0020);
      check("st_if_adv",   32'(if_advance), 32'h0);
      tick();
      drive(1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
      check("ld_rdata", 32'(mem_rdata), 32'hBEEF);
      tick();

      // Build three entries, then flush
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 6'b000100, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
      check("pre_flush_q", 32'(q_count), 32'h3);
      drive(1'b1, 6'b000100, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      check("flush_if_adv", 32'(if_advance), 32'h0);
      tick();
      check("flush_q_count",  32'(q_count),  32'h0);
      check("flush_id_valid", 32'(id_valid), 32'h0);
      check("flush_id_inst",  32'(id_inst),  32'(NOP));

      // IF stalled with empty queue: ID receives a NOP bubble
      drive(1'b1, 6'b000010, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      check("bubble_id_valid", 32'(id_valid), 32'h0);
      check("bubble_id_inst",  32'(id_inst),  32'(NOP));

      // Mixed directed patterns exercise pointer wrap and ignored stall bits
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 16; k++) begin
            drive(1'b1, pat[k][7:2], 1'b0, pat[k][1], pat[k][0],
                  16'h0080 + 16'(k), 16'hA000 + 16'(k + p));
            tick();
         end
      end

      // Reset while full with a store pending
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 6'b000100, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
      check("pre_rst_q", 32'(q_count), 32'h4);
      drive(1'b0, 6'b000100, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h1234);
      check("rst2_ram_we", 32'(ram_we_o), 32'h0);
      tick();
      check("rst2_id_pc",    32'(id_pc),    32'h0);
      check("rst2_id_inst",  32'(id_inst),  32'(NOP));
      check("rst2_id_valid", 32'(id_valid), 32'h0);
      check("rst2_q_count",  32'(q_count),  32'h0);
      drive(1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      check("rst2_no_store", 32'(mem_rdata), 32'h1030);
      tick();

      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         tick();
      end
      drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
